// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 32-bit MIPS-style ALU: decodes one instruction, registers ALU operands, returns the result.
// Latency: legal bundle accepted at edge N -> res_valid after edge N+2; illegal bundle -> res_valid after edge N+1.
// Backpressure: one operation in flight; in_ready only in IDLE; result held in RESP until res_ready.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  // instruction / operand bundle
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  // external ALU
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  // result handshake
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_zero,
  output logic        res_carry,
  output logic        res_overflow,
  output logic        res_illegal,
  output logic        res_branch_taken,
  // completed-result counter
  output logic [15:0] op_count
);

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_control_q;
  logic        is_beq_q;
  logic        res_valid_q;
  logic [31:0] res_data_q;
  logic        res_zero_q;
  logic        res_carry_q;
  logic        res_overflow_q;
  logic        res_illegal_q;
  logic        res_branch_taken_q;
  logic [15:0] op_count_q;

  // decode results, only consumed at the accept edge
  logic        legal_d;
  logic [3:0]  alu_control_d;
  logic [31:0] alu_b_d;
  logic        is_beq_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  // register-specifier fields are not needed: operand values arrive already read
  logic        unused_instr_fields;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};
  assign unused_instr_fields = ^instr[25:16];

  // Decode opcode/funct into ALU op, B-operand source and branch marker
  always_comb begin
    legal_d       = 1'b0;
    alu_control_d = ALU_AND;
    alu_b_d       = rt_val;
    is_beq_d      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_b_d = rt_val;
        case (funct)
          FN_ADD:  begin legal_d = 1'b1; alu_control_d = ALU_ADD; end
          FN_SUB:  begin legal_d = 1'b1; alu_control_d = ALU_SUB; end
          FN_AND:  begin legal_d = 1'b1; alu_control_d = ALU_AND; end
          FN_OR:   begin legal_d = 1'b1; alu_control_d = ALU_OR;  end
          FN_NOR:  begin legal_d = 1'b1; alu_control_d = ALU_NOR; end
          FN_SLT:  begin legal_d = 1'b1; alu_control_d = ALU_SLT; end
          default: legal_d = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        legal_d       = 1'b1;
        alu_control_d = ALU_ADD;
        alu_b_d       = imm_sext;
      end
      OP_SLTI: begin
        legal_d       = 1'b1;
        alu_control_d = ALU_SLT;
        alu_b_d       = imm_sext;
      end
      OP_ANDI: begin
        legal_d       = 1'b1;
        alu_control_d = ALU_AND;
        alu_b_d       = imm_zext;
      end
      OP_ORI: begin
        legal_d       = 1'b1;
        alu_control_d = ALU_OR;
        alu_b_d       = imm_zext;
      end
      OP_BEQ: begin
        legal_d       = 1'b1;
        alu_control_d = ALU_SUB;
        alu_b_d       = rt_val;
        is_beq_d      = 1'b1;
      end
      default: legal_d = 1'b0;
    endcase
  end

  // Control FSM with registered operand, result and counter outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      in_ready_q         <= 1'b1;
      alu_a_q            <= 32'h0;
      alu_b_q            <= 32'h0;
      alu_control_q      <= ALU_AND;
      is_beq_q           <= 1'b0;
      res_valid_q        <= 1'b0;
      res_data_q         <= 32'h0;
      res_zero_q         <= 1'b0;
      res_carry_q        <= 1'b0;
      res_overflow_q     <= 1'b0;
      res_illegal_q      <= 1'b0;
      res_branch_taken_q <= 1'b0;
      op_count_q         <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (legal_d) begin
              // operands stay frozen in these registers for the whole EXEC cycle
              alu_a_q       <= rs_val;
              alu_b_q       <= alu_b_d;
              alu_control_q <= alu_control_d;
              is_beq_q      <= is_beq_d;
              state_q       <= EXEC;
            end else begin
              // illegal bundle skips the ALU; operand registers keep their old values
              res_valid_q        <= 1'b1;
              res_data_q         <= 32'h0;
              res_zero_q         <= 1'b0;
              res_carry_q        <= 1'b0;
              res_overflow_q     <= 1'b0;
              res_illegal_q      <= 1'b1;
              res_branch_taken_q <= 1'b0;
              state_q            <= RESP;
            end
          end
        end
        EXEC: begin
          res_valid_q        <= 1'b1;
          res_data_q         <= alu_result;
          res_zero_q         <= alu_zero;
          res_carry_q        <= alu_carry;
          res_overflow_q     <= alu_overflow;
          res_illegal_q      <= 1'b0;
          res_branch_taken_q <= is_beq_q && alu_zero;
          state_q            <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_control      = alu_control_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_zero         = res_zero_q;
  assign res_carry        = res_carry_q;
  assign res_overflow     = res_overflow_q;
  assign res_illegal      = res_illegal_q;
  assign res_branch_taken = res_branch_taken_q;
  assign op_count         = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 32-bit ALU attached.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_overflow;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_carry;
  logic        res_overflow;
  logic        res_illegal;
  logic        res_branch_taken;
  logic [15:0] op_count;

  int tests = 0;
  int fails = 0;
  int lat;
  logic [3:0]  exec_ctrl;
  logic [31:0] exec_a;
  logic [31:0] exec_b;

  alu_issue_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instr            (instr),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_control      (alu_control),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .alu_carry        (alu_carry),
    .alu_overflow     (alu_overflow),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_zero         (res_zero),
    .res_carry        (res_carry),
    .res_overflow     (res_overflow),
    .res_illegal      (res_illegal),
    .res_branch_taken (res_branch_taken),
    .op_count         (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU driven by the DUT's registered operands
  always_comb begin
    logic [32:0] sum;
    sum          = 33'h0;
    alu_result   = 32'h0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0010: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[31:0];
        alu_carry    = sum[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'b0110: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result   = sum[31:0];
        alu_carry    = sum[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a bundle at a falling edge, let it be accepted, then wait (bounded) for res_valid.
  task automatic do_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = ins;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk);
    @(negedge clk);
    exec_ctrl = alu_control;
    exec_a    = alu_a;
    exec_b    = alu_b;
    in_valid  = 1'b0;
    instr     = 32'h0000_0020;
    rs_val    = $urandom;
    rt_val    = $urandom;
    lat = 1;
    while (!res_valid && lat < 6) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ret_op();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    instr     = 32'h0;
    rs_val    = 32'h0;
    rt_val    = 32'h0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_flags", {res_zero, res_carry, res_overflow, res_illegal, res_branch_taken}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_control, 0);
    chk("rst_op_count", op_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // add 5 + 7
    do_op(32'h0000_0020, 32'd5, 32'd7);
    chk("add_ctrl", exec_ctrl, 4'b0010);
    chk("add_a", exec_a, 5);
    chk("add_b", exec_b, 7);
    chk("add_lat", lat, 2);
    chk("add_data", res_data, 12);
    chk("add_flags", {res_zero, res_carry, res_overflow, res_illegal, res_branch_taken}, 0);
    chk("add_in_ready", in_ready, 0);
    ret_op();
    chk("add_cnt", op_count, 1);
    chk("add_idle", in_ready, 1);
    chk("add_vld_low", res_valid, 0);

    // addi signed overflow
    do_op(32'h2000_0001, 32'h7FFF_FFFF, 32'h0);
    chk("addi_b", exec_b, 1);
    chk("addi_data", res_data, 32'h8000_0000);
    chk("addi_ovf", res_overflow, 1);
    chk("addi_carry", res_carry, 0);
    ret_op();

    // addi with negative immediate: sign extension
    do_op(32'h2000_FFFF, 32'd5, 32'h0);
    chk("addin_b", exec_b, 32'hFFFF_FFFF);
    chk("addin_data", res_data, 4);
    chk("addin_carry", res_carry, 1);
    ret_op();

    // andi: zero extension
    do_op(32'h3000_FFFF, 32'hFFFF_FFFF, 32'h0);
    chk("andi_ctrl", exec_ctrl, 4'b0000);
    chk("andi_b", exec_b, 32'h0000_FFFF);
    chk("andi_data", res_data, 32'h0000_FFFF);
    ret_op();

    // beq taken
    do_op(32'h1000_0000, 32'h1234, 32'h1234);
    chk("beq_ctrl", exec_ctrl, 4'b0110);
    chk("beq_zero", res_zero, 1);
    chk("beq_taken", res_branch_taken, 1);
    ret_op();

    // beq not taken
    do_op(32'h1000_0000, 32'd1, 32'd2);
    chk("beqn_taken", res_branch_taken, 0);
    chk("beqn_data", res_data, 32'hFFFF_FFFF);
    ret_op();

    // slt signed
    do_op(32'h0000_002A, 32'hFFFF_FFFF, 32'd1);
    chk("slt_ctrl", exec_ctrl, 4'b0111);
    chk("slt_data", res_data, 1);
    ret_op();

    // nor
    do_op(32'h0000_0027, 32'h0F0F_0000, 32'h00F0_000F);
    chk("nor_ctrl", exec_ctrl, 4'b1100);
    chk("nor_data", res_data, 32'hF000_FFF0);
    chk("nor_zero", res_zero, 0);
    ret_op();

    // illegal opcode
    do_op(32'hFC00_0000, 32'd9, 32'd9);
    chk("ill_lat", lat, 1);
    chk("ill_flag", res_illegal, 1);
    chk("ill_data", res_data, 0);
    chk("ill_flags", {res_zero, res_carry, res_overflow, res_branch_taken}, 0);
    chk("ill_ctrl_kept", alu_control, 4'b1100);
    chk("ill_a_kept", alu_a, 32'h0F0F_0000);
    ret_op();
    chk("ill_cnt", op_count, 9);

    // illegal R-type funct
    do_op(32'h0000_0001, 32'd3, 32'd4);
    chk("illf_lat", lat, 1);
    chk("illf_flag", res_illegal, 1);
    ret_op();

    // sub with backpressure and in_valid held high
    do_op(32'h0000_0022, 32'd10, 32'd3);
    chk("sub_data", res_data, 7);
    in_valid = 1'b1;
    instr    = 32'h0000_0020;
    rs_val   = 32'd100;
    rt_val   = 32'd200;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data", res_data, 7);
      chk("bp_ctrl", alu_control, 4'b0110);
    end
    in_valid = 1'b0;
    ret_op();
    chk("bp_cnt", op_count, 11);
    chk("bp_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("idle_ctrl_kept", alu_control, 4'b0110);
    chk("idle_stays", in_ready, 1);

    // reset in the middle of EXEC
    in_valid = 1'b1;
    instr    = 32'h0000_0020;
    rs_val   = 32'd5;
    rt_val   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mx_exec_ctrl", alu_control, 4'b0010);
    #1 rst = 1'b1;
    #1;
    chk("mx_in_ready", in_ready, 1);
    chk("mx_valid", res_valid, 0);
    chk("mx_ctrl", alu_control, 0);
    chk("mx_a", alu_a, 0);
    chk("mx_cnt", op_count, 0);
    @(negedge clk);
    rst       = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mx_no_result", res_valid, 0);
    chk("mx_no_count", op_count, 0);
    res_ready = 1'b0;

    // reset in the middle of RESP
    do_op(32'h0000_0020, 32'd1, 32'd1);
    chk("mr_pre_valid", res_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_valid", res_valid, 0);
    chk("mr_data", res_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_cnt", op_count, 0);

    // counter wrap: two cycles per illegal op with both handshakes held high
    in_valid  = 1'b1;
    instr     = 32'hFC00_0000;
    res_ready = 1'b1;
    repeat (2 * 65535) @(posedge clk);
    @(negedge clk);
    chk("wrap_ffff", op_count, 16'hFFFF);
    chk("wrap_pre_idle", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    chk("wrap_zero", op_count, 0);
    chk("wrap_idle", in_ready, 1);
    chk("wrap_valid", res_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  instruction/operand bundle valid.
REQ-004 in_ready  out  1  block can accept a bundle.
REQ-005 instr  in  32  MIPS-format word: opcode [31:26], funct [5:0], imm [15:0].
REQ-006 rs_val, rt_val  in  32 each  register operands.
REQ-007 alu_a, alu_b  out  32 each  registered operands to the 32-bit ALU.
REQ-008 alu_control  out  4  registered ALU op code: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-009 alu_result  in  32; alu_zero, alu_carry, alu_overflow  in  1 each  combinational ALU returns.
REQ-010 res_valid  out  1; res_ready  in  1  result handshake.
REQ-011 res_data  out  32; res_zero, res_carry, res_overflow, res_illegal, res_branch_taken  out  1 each.
REQ-012 op_count  out  16  completed-result counter.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP; in_ready SHALL be 1 only in IDLE.
REQ-014 Transfer occurs when in_valid && in_ready at a rising edge; instr, rs_val, rt_val SHALL be captured then and ignored otherwise.
REQ-015 R-type (opcode 000000) decode: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT; alu_a=rs_val, alu_b=rt_val.
REQ-016 I-type decode: 001000 addi ADD, 001010 slti SLT, 100011 lw ADD, 101011 sw ADD (all sign-extended imm as alu_b); 001100 andi AND, 001101 ori OR (zero-extended imm); 000100 beq SUB with alu_b=rt_val; alu_a=rs_val in all cases.
REQ-017 Legal accept: IDLE -> EXEC; alu_a, alu_b, alu_control SHALL be registered at the accept edge and held stable through EXEC.
REQ-018 EXEC -> RESP after exactly one cycle; at that edge res_data, res_zero, res_carry, res_overflow SHALL capture alu_result and ALU flags, res_illegal=0.
REQ-019 res_branch_taken SHALL be 1 only for beq with alu_zero=1 captured in EXEC.
REQ-020 Illegal opcode/funct: IDLE -> RESP directly; res_illegal=1, res_data=0, all other flags 0; alu_* outputs unchanged.
REQ-021 Latency: legal accept at edge N gives res_valid=1 after edge N+2; illegal gives res_valid=1 after edge N+1.
REQ-022 In RESP res_valid=1 and all res_* outputs SHALL hold stable until res_ready=1 at an edge, then RESP -> IDLE.
REQ-023 in_valid during EXEC/RESP SHALL be ignored (no accept, no state change); no back-to-back accept before returning to IDLE.
REQ-024 op_count SHALL increment by 1 on each res_valid && res_ready edge (legal and illegal), wrapping 0xFFFF -> 0x0000.
REQ-025 alu_control during IDLE SHALL retain its last value; no combinational path from in_* to alu_* or res_*.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, in_ready=1, res_valid=0, all res_* flags 0, res_data=0, alu_a=alu_b=0, alu_control=0000, op_count=0.
REQ-027 rst asserted mid-EXEC or mid-RESP SHALL abort the operation with no result delivered and no op_count increment.

Verification
REQ-028 add: instr R-type funct 100000, rs=5, rt=7 -> alu_control 0010 during EXEC, res_data=12, flags 0, res_valid 2 cycles after accept.
REQ-029 addi overflow: rs=0x7FFFFFFF, imm=0x0001 -> res_data=0x80000000, res_overflow=1; andi imm=0xFFFF, rs=0xFFFFFFFF -> res_data=0x0000FFFF.
REQ-030 beq: rs=rt=0x1234 -> alu_control 0110, res_zero=1, res_branch_taken=1; rs=1, rt=2 -> res_branch_taken=0, res_data=0xFFFFFFFF.
REQ-031 slt: rs=0xFFFFFFFF (-1), rt=1 -> res_data=1; illegal opcode 111111 -> res_illegal=1, res_data=0, res_valid 1 cycle after accept.
REQ-032 backpressure: hold res_ready=0 for 5 cycles with in_valid=1 -> res_* stable, in_ready=0, no new accept; release -> op_count+1, IDLE next.
REQ-033 reset mid-EXEC, then 65536 completed ops -> outputs at reset values, op_count wraps to 0.
